// File: rtl/mips_defs.sv
// Shared MIPS datapath definitions: bus widths and memory-arbiter state encoding.
package mips_defs;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/register.sv
// Generic load-enable register with asynchronous active-high clear.
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and MEM-stage accesses,
// data-priority with a bounded starvation window for fetch.
module mem_arbiter
    import mips_defs::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              stall
);

    arb_state_t state, state_nxt;

    logic grant_d, grant_if, grant;
    logic cap_if, cap_d;
    logic we_q, owner_d_q;
    logic at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_if  = 1'b0;
        cap_if    = 1'b0;
        cap_d     = 1'b0;
        case (state)
            IDLE: begin
                // Fetch overrides data only once the starvation window is used up.
                if (d_req && !(if_req && at_limit)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (m_ready) begin
                    cap_if    = 1'b1;
                    state_nxt = DONE;
                end
            end
            BUSY_D: begin
                if (m_ready) begin
                    cap_d     = ~we_q;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign grant = grant_d | grant_if;

    register #(.WIDTH(ADDR_W)) u_addr_reg (
        .clk (clk),
        .rst (rst),
        .en  (grant),
        .d   (grant_d ? d_addr : if_addr),
        .q   (m_addr)
    );

    register #(.WIDTH(DATA_W)) u_wdata_reg (
        .clk (clk),
        .rst (rst),
        .en  (grant),
        .d   (grant_d ? d_wdata : '0),
        .q   (m_wdata)
    );

    register #(.WIDTH(1)) u_we_reg (
        .clk (clk),
        .rst (rst),
        .en  (grant),
        .d   (grant_d & d_we),
        .q   (we_q)
    );

    register #(.WIDTH(1)) u_owner_reg (
        .clk (clk),
        .rst (rst),
        .en  (grant),
        .d   (grant_d),
        .q   (owner_d_q)
    );

    register #(.WIDTH(DATA_W)) u_if_rdata_reg (
        .clk (clk),
        .rst (rst),
        .en  (cap_if),
        .d   (m_rdata),
        .q   (if_rdata)
    );

    register #(.WIDTH(DATA_W)) u_d_rdata_reg (
        .clk (clk),
        .rst (rst),
        .en  (cap_d),
        .d   (m_rdata),
        .q   (d_rdata)
    );

    starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (grant_d & if_req),
        .clr      (grant_if | (grant_d & ~if_req)),
        .at_limit (at_limit)
    );

    assign m_req  = (state == BUSY_IF) || (state == BUSY_D);
    assign m_we   = m_req & we_q;
    assign if_ack = (state == DONE) & ~owner_d_q;
    assign d_ack  = (state == DONE) & owner_d_q;
    assign stall  = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter against a behavioural model.
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        stall;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Transaction model: 0 = no transfer, 1 = memory access outstanding, 2 = ack cycle.
    int          phase;
    bit          who_d;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    bit          lat_we;
    int          starve;
    int          wait_left;
    int          data_run;
    int          max_data_run;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase        = 0;
        who_d        = 1'b0;
        lat_addr     = '0;
        lat_wdata    = '0;
        lat_we       = 1'b0;
        starve       = 0;
        wait_left    = 0;
        data_run     = 0;
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check_val("rst_m_req",    32'(m_req),  32'd0);
        check_val("rst_m_we",     32'(m_we),   32'd0);
        check_val("rst_if_ack",   32'(if_ack), 32'd0);
        check_val("rst_d_ack",    32'(d_ack),  32'd0);
        check_val("rst_m_addr",   m_addr,      32'd0);
        check_val("rst_m_wdata",  m_wdata,     32'd0);
        check_val("rst_if_rdata", if_rdata,    32'd0);
        check_val("rst_d_rdata",  d_rdata,     32'd0);
        check_val("rst_stall",    32'(stall),  32'(if_req | d_req));
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic step(input int mode);
        logic exp_if_ack, exp_d_ack, want;
        bit   data_wins;
        @(negedge clk);
        exp_if_ack = (phase == 2) && !who_d;
        exp_d_ack  = (phase == 2) && who_d;
        check_val("m_req",    32'(m_req),  32'(phase == 1));
        check_val("m_we",     32'(m_we),   32'((phase == 1) && lat_we));
        check_val("m_addr",   m_addr,      lat_addr);
        if (phase == 1 && lat_we) check_val("m_wdata", m_wdata, lat_wdata);
        check_val("if_ack",   32'(if_ack), 32'(exp_if_ack));
        check_val("d_ack",    32'(d_ack),  32'(exp_d_ack));
        check_val("if_rdata", if_rdata,    exp_if_rdata);
        check_val("d_rdata",  d_rdata,     exp_d_rdata);

        // Requesters hold until acked, then may immediately issue a new request.
        if (exp_if_ack) if_req = 1'b0;
        if (exp_d_ack)  d_req  = 1'b0;
        want = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
        if (!if_req && want) begin
            if_req  = 1'b1;
            if_addr = $urandom() & 32'hFFFF_FFFC;
        end
        want = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
        if (!d_req && want) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = $urandom() & 32'hFFFF_FFFC;
            d_wdata = $urandom();
        end

        m_rdata = $urandom();
        if (phase == 1) begin
            if (wait_left == 0) begin
                m_ready = 1'b1;
            end else begin
                m_ready = 1'b0;
                wait_left--;
            end
        end else begin
            m_ready = 1'($urandom_range(0, 1));
        end

        #1;
        check_val("stall", 32'(stall), 32'((if_req && !exp_if_ack) || (d_req && !exp_d_ack)));

        // What the coming clock edge does.
        if (phase == 0) begin
            if (if_req || d_req) begin
                data_wins = d_req && !(if_req && starve == LIMIT);
                who_d     = data_wins;
                wait_left = $urandom_range(0, 3);
                if (data_wins) begin
                    lat_addr  = d_addr;
                    lat_wdata = d_wdata;
                    lat_we    = d_we;
                    starve    = if_req ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
                    data_run  = if_req ? data_run + 1 : 0;
                    if (data_run > max_data_run) max_data_run = data_run;
                end else begin
                    lat_addr = if_addr;
                    lat_we   = 1'b0;
                    starve   = 0;
                    data_run = 0;
                end
                phase = 1;
            end
        end else if (phase == 1) begin
            if (m_ready) begin
                if (!who_d)       exp_if_rdata = m_rdata;
                else if (!lat_we) exp_d_rdata  = m_rdata;
                phase = 2;
            end
        end else begin
            phase = 0;
        end
    endtask

    initial begin
        int resets_done;
        rst     = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_rdata = '0;
        m_ready = 1'b0;
        max_data_run = 0;
        resets_done  = 0;
        apply_reset();

        // Idle bus with noise on m_ready: nothing may start or ack.
        repeat (20) step(2);
        // Both requesters saturated: data runs capped by the starvation window.
        repeat (150) step(1);
        check_val("starve_run_cap", 32'(max_data_run), 32'(LIMIT));
        repeat (10) step(2);

        for (int i = 0; i < 1500; i++) begin
            step(0);
            if (phase == 1 && resets_done < 4 && $urandom_range(0, 40) == 0) begin
                resets_done++;
                apply_reset();
            end
        end
        repeat (20) step(2);
        check_val("resets_applied", 32'(resets_done > 0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
